// File: rtl/branch_pkg.sv
// Shared branch-unit types: RV32I branch conditions and saturating-counter helpers.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  localparam int CTR_MIN       = 0;
  localparam int CTR_BITS_DFLT = 2;
  localparam int CTR_RST_DFLT  = (1 << (CTR_BITS_DFLT - 1)) - 1;
  localparam int CTR_MAX_DFLT  = (1 << CTR_BITS_DFLT) - 1;

  // 010 and 011 are unassigned in the branch opcode space.
  function automatic logic is_legal_br(input logic [2:0] funct3);
    return funct3[2:1] != 2'b01;
  endfunction

  function automatic int ctr_rst_val(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int ctr_max_val(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: (funct3, rs1, rs2) -> taken, legal.
// Purely combinational, no backpressure.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            legal
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      BEQ:     taken = (rs1 == rs2);
      BNE:     taken = (rs1 != rs2);
      BLT:     taken = ($signed(rs1) <  $signed(rs2));
      BGE:     taken = ($signed(rs1) >= $signed(rs2));
      BLTU:    taken = (rs1 <  rs2);
      BGEU:    taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

  assign legal = is_legal_br(funct3);

endmodule

// File: rtl/branch_unit_bht.sv
// Branch unit: BHT lookup at fetch, condition resolve and counter training in EX.
// Lookup/resolve combinational; mispredict/illegal_br/counters registered 1 cycle; no backpressure.
module branch_unit_bht
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  output logic             ex_taken,
  output logic             mispredict,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_rst_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_LO  = CTR_BITS'(CTR_MIN);

  logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
  logic [IDX_W-1:0]    if_idx;
  logic [IDX_W-1:0]    ex_idx;
  logic [CTR_BITS-1:0] ctr_old;
  logic [CTR_BITS-1:0] ctr_next;
  logic                cmp_taken;
  logic                cmp_legal;
  logic                is_br;
  logic                upd;
  logic                unused_pc_bits;

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc, ex_pc};

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3 (ex_funct3),
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .taken  (cmp_taken),
    .legal  (cmp_legal)
  );

  assign is_br         = ex_valid & ex_is_branch;
  assign upd           = is_br & cmp_legal;
  assign ex_taken      = is_br & cmp_taken;
  assign if_pred_taken = if_valid & bht[if_idx][CTR_BITS-1];

  always_comb begin
    ctr_old  = bht[ex_idx];
    ctr_next = ctr_old;
    if (cmp_taken) begin
      if (ctr_old != CTR_MAX) ctr_next = ctr_old + CTR_BITS'(1);
    end else begin
      if (ctr_old != CTR_LO) ctr_next = ctr_old - CTR_BITS'(1);
    end
  end

  // Lookup reads the array directly, so a same-cycle update is seen only next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RST;
    end else if (upd) begin
      bht[ex_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict    <= 1'b0;
      illegal_br    <= 1'b0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      mispredict <= upd & (cmp_taken != ex_pred_taken);
      illegal_br <= is_br & ~cmp_legal;
      if (upd) br_count <= br_count + CNT_W'(1);
      if (upd & (cmp_taken != ex_pred_taken)) mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_unit_bht.sv
// Scoreboard bench for branch_unit_bht: directed corners plus random traffic vs a reference model.
module tb_branch_unit_bht;

  localparam int ENT  = 64;
  localparam int CB   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CB) - 1;
  localparam int CRST = (1 << (CB - 1)) - 1;
  localparam int HALF = 1 << (CB - 1);
  localparam int CMOD = 1 << CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, if_valid, if_pred_taken;
  logic          ex_valid, ex_is_branch, ex_pred_taken, ex_taken;
  logic          mispredict, illegal_br;
  logic [31:0]   if_pc, ex_rs1, ex_rs2, ex_pc;
  logic [2:0]    ex_funct3;
  logic [CW-1:0] br_count, mispred_count;

  branch_unit_bht #(.XLEN(32), .BHT_ENTRIES(ENT), .CTR_BITS(CB), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_funct3     (ex_funct3),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_pc         (ex_pc),
    .ex_pred_taken (ex_pred_taken),
    .ex_taken      (ex_taken),
    .mispredict    (mispredict),
    .illegal_br    (illegal_br),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  typedef struct {
    int cyc;
    bit is_reg;
    bit a;
    bit b;
    int c0;
    int c1;
  } exp_t;

  typedef struct {
    bit          rst;
    bit          ifv;
    logic [31:0] ifpc;
    bit          exv;
    bit          isbr;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] expc;
    bit          pred;
  } stim_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   bht_m[ENT];
  int   brc_m = 0;
  int   mpc_m = 0;
  bit   model_known = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop every expectation due in this cycle and compare against the live outputs.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc != cyc) chk("sb_order", mon_e.cyc, cyc);
      else if (!mon_e.is_reg) begin
        chk("if_pred_taken", {31'b0, if_pred_taken}, {31'b0, mon_e.a});
        chk("ex_taken", {31'b0, ex_taken}, {31'b0, mon_e.b});
      end else begin
        chk("mispredict", {31'b0, mispredict}, {31'b0, mon_e.a});
        chk("illegal_br", {31'b0, illegal_br}, {31'b0, mon_e.b});
        chk("br_count", {28'b0, br_count}, mon_e.c0);
        chk("mispred_count", {28'b0, mispred_count}, mon_e.c1);
      end
    end
  end

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc / 4) % ENT;
  endfunction

  function automatic bit ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_;
    longint ua, ub;
    sa = longint'($signed(a)); sb_ = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    case (f)
      3'd0:    return ua == ub;
      3'd1:    return ua != ub;
      3'd4:    return sa < sb_;
      3'd5:    return sa >= sb_;
      3'd6:    return ua < ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t look(input logic [31:0] pc);
    stim_t s;
    s = idle();
    s.ifv = 1'b1; s.ifpc = pc;
    return s;
  endfunction

  function automatic stim_t br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input bit pred);
    stim_t s;
    s = idle();
    s.exv = 1'b1; s.isbr = 1'b1; s.f3 = f; s.rs1 = a; s.rs2 = b; s.expc = pc; s.pred = pred;
    return s;
  endfunction

  // Drive one cycle, predict its outcome from the model and queue the expectations.
  task automatic step(input stim_t s);
    bit   is_br, legal, tk, mis;
    int   i, c;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = !s.rst; if_valid = s.ifv; if_pc = s.ifpc;
    ex_valid = s.exv; ex_is_branch = s.isbr; ex_funct3 = s.f3;
    ex_rs1 = s.rs1; ex_rs2 = s.rs2; ex_pc = s.expc; ex_pred_taken = s.pred;
    is_br = s.exv && s.isbr;
    legal = (s.f3 != 3'd2) && (s.f3 != 3'd3);
    tk    = is_br && ref_taken(s.f3, s.rs1, s.rs2);
    if (model_known) begin
      e = '{cyc, 1'b0, s.ifv && (bht_m[idx_of(s.ifpc)] >= HALF), tk, 0, 0};
      sb.push_back(e);
    end
    if (s.rst) begin
      for (int k = 0; k < ENT; k++) bht_m[k] = CRST;
      brc_m = 0; mpc_m = 0; model_known = 1'b1;
      e = '{cyc + 1, 1'b1, 1'b0, 1'b0, 0, 0};
      sb.push_back(e);
    end else if (model_known) begin
      mis = is_br && legal && (tk != s.pred);
      if (is_br && legal) begin
        i = idx_of(s.expc);
        c = bht_m[i];
        bht_m[i] = tk ? ((c + 1 > CMAX) ? CMAX : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
        brc_m = (brc_m + 1) % CMOD;
        if (mis) mpc_m = (mpc_m + 1) % CMOD;
      end
      e = '{cyc + 1, 1'b1, mis, is_br && !legal, brc_m, mpc_m};
      sb.push_back(e);
    end
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_is_branch = 1'b0;
    ex_funct3 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_pred_taken = 1'b0;

    // Reset, then cold lookups.
    s = idle(); s.rst = 1'b1;
    step(s); step(s);
    step(look(32'h0)); step(look(32'h4)); step(look(32'h100)); step(look(32'hFC));

    // Signed/unsigned corners.
    step(br(3'd4, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b1));
    step(br(3'd6, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0));
    step(br(3'd5, 32'h8000_0000, 32'h8000_0000, 32'h44, 1'b1));
    step(br(3'd7, 32'h8000_0000, 32'h8000_0000, 32'h48, 1'b1));

    // Training at 0x100 to saturation, aliasing at 0x200.
    step(br(3'd0, 32'h5, 32'h5, 32'h100, 1'b0));
    step(br(3'd0, 32'h5, 32'h5, 32'h100, 1'b0));
    step(br(3'd0, 32'h5, 32'h5, 32'h100, 1'b1));
    step(br(3'd0, 32'h5, 32'h5, 32'h100, 1'b1));
    step(look(32'h100)); step(look(32'h200));

    // Same-cycle lookup and not-taken update of one entry returns the old value.
    s = br(3'd1, 32'h7, 32'h7, 32'h100, 1'b1); s.ifv = 1'b1; s.ifpc = 32'h100;
    step(s); step(s); step(s);
    step(look(32'h100));

    // Illegal funct3 leaves BHT and counters alone.
    s = br(3'd2, 32'h1, 32'h1, 32'h200, 1'b0); s.ifv = 1'b1; s.ifpc = 32'h200;
    step(s);
    s.f3 = 3'd3;
    step(s);
    step(look(32'h200));

    // Reset colliding with a mispredicting resolve.
    s = br(3'd0, 32'h9, 32'h9, 32'h40, 1'b0); s.rst = 1'b1;
    step(s);
    step(look(32'h40)); step(look(32'h100));

    // Counter wrap at 16 branches.
    for (int n = 0; n < 16; n++) step(br(3'd1, 32'h1, 32'h2, 32'h300, 1'b1));
    step(idle());

    // Random traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      s = idle();
      s.rst  = ($urandom_range(0, 79) == 0);
      s.ifv  = 1'($urandom_range(0, 1));
      s.ifpc = 32'($urandom_range(0, 511));
      s.exv  = ($urandom_range(0, 3) != 0);
      s.isbr = ($urandom_range(0, 4) != 0);
      s.f3   = 3'($urandom_range(0, 7));
      s.rs1  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom);
      s.rs2  = ($urandom_range(0, 2) == 0) ? s.rs1 : 32'($urandom);
      s.expc = 32'($urandom_range(0, 511));
      s.pred = 1'($urandom_range(0, 1));
      step(s);
    end

    step(idle());
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
